hazard_run_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage 16-bit core datapath. It detects RAW hazards between the instruction in ID and in-flight destinations in EX/MEM/WB. The datapath has no forwarding and no register-file write-through, so the controller holds PC and IF/ID and injects bubbles into ID/EX. It also provides host run-control (halt, drain, single-step, resume) and saturating stall/issue counters.

---
 rtl/hazard_run_ctrl_pkg.sv | 21 ++
 rtl/hazard_scoreboard.sv | 70 +++++++
 rtl/hazard_run_ctrl.sv | 109 ++++++++++
 tb/tb_hazard_run_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_run_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: run-control states
// and the in-flight destination entry tracked past ID.
package hazard_run_ctrl_pkg;

    localparam int unsigned CORE_REG_AW   = 3;
    localparam int unsigned CORE_CNT_W    = 16;
    localparam int unsigned CORE_SB_DEPTH = 3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED,
        ST_STEP
    } run_state_e;

    typedef struct packed {
        logic                   valid;
        logic [CORE_REG_AW-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Destination shift register covering EX/MEM/WB plus RAW match against the
// ID source operands.
module hazard_scoreboard
    import hazard_run_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = CORE_REG_AW,
    parameter int unsigned SB_DEPTH = CORE_SB_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_valid_i,
    input  logic [REG_AW-1:0] load_rd_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic              rs1_used_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              rs2_used_i,
    output logic              hazard_o,
    output logic              empty_o
);

    sb_entry_t slot_q [SB_DEPTH];
    sb_entry_t slot_d [SB_DEPTH];
    logic      hit1;
    logic      hit2;

    // The pipeline past ID never stalls, so the shift happens every cycle.
    always_comb begin
        slot_d[0].valid = load_valid_i;
        slot_d[0].rd    = load_rd_i;
        for (int unsigned k = 1; k < SB_DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned k = 0; k < SB_DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < SB_DEPTH; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    // No write-through: a match in the WB slot is still a hazard.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            if (slot_q[k].valid && (slot_q[k].rd == rs1_i)) hit1 = 1'b1;
            if (slot_q[k].valid && (slot_q[k].rd == rs2_i)) hit2 = 1'b1;
        end
    end

    assign hazard_o = id_valid_i &
                      ((rs1_used_i & (rs1_i != '0) & hit1) |
                       (rs2_used_i & (rs2_i != '0) & hit2));

    // Looks at the post-edge contents so DRAIN ends as the last WB retires.
    always_comb begin
        empty_o = 1'b1;
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            if (slot_d[k].valid) empty_o = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_run_ctrl.sv
// Pipeline sequencing controller: RAW stall/bubble generation, host
// run-control (halt/drain/step/resume) and saturating stall/issue counters.
module hazard_run_ctrl
    import hazard_run_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = CORE_REG_AW,
    parameter int unsigned CNT_W    = CORE_CNT_W,
    parameter int unsigned SB_DEPTH = CORE_SB_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic              id_reg_write_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              halt_req_i,
    input  logic              resume_i,
    input  logic              step_i,
    output logic              pc_hold_o,
    output logic              bubble_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  issue_cnt_o
);

    run_state_e        state_q;
    run_state_e        state_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [CNT_W-1:0]  issue_cnt_d;
    logic              hazard;
    logic              sb_empty;
    logic              may_issue;
    logic              issue;
    logic              sb_load;

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .SB_DEPTH (SB_DEPTH)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .load_valid_i (sb_load),
        .load_rd_i    (id_rd_i),
        .id_valid_i   (id_valid_i),
        .rs1_i        (id_rs1_i),
        .rs1_used_i   (id_rs1_used_i),
        .rs2_i        (id_rs2_i),
        .rs2_used_i   (id_rs2_used_i),
        .hazard_o     (hazard),
        .empty_o      (sb_empty)
    );

    always_comb begin
        may_issue = (state_q == ST_RUN) || (state_q == ST_STEP);
        issue     = id_valid_i & ~hazard & may_issue;
        sb_load   = issue & id_reg_write_i & (id_rd_i != '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (halt_req_i) state_d = ST_DRAIN;
            ST_DRAIN:  if (sb_empty)   state_d = ST_HALTED;
            ST_HALTED: begin
                if (resume_i)    state_d = ST_RUN;
                else if (step_i) state_d = ST_STEP;
            end
            ST_STEP:   if (issue)      state_d = ST_DRAIN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_hold_o = ~issue & (hazard ||
                              (state_q == ST_DRAIN) ||
                              (state_q == ST_HALTED) ||
                              ((state_q == ST_STEP) && !id_valid_i));
        bubble_o  = pc_hold_o;
        halted_o  = (state_q == ST_HALTED);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        issue_cnt_d = issue_cnt_q;
        if (hazard && may_issue && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (issue && (issue_cnt_q != '1))               issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end

    assign stall_cnt_o = stall_cnt_q;
    assign issue_cnt_o = issue_cnt_q;

endmodule

// File: tb/tb_hazard_run_ctrl.sv
// Directed bench for hazard_run_ctrl; a narrow-counter instance shares the
// stimulus to exercise saturation.
module tb_hazard_run_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       id_valid_i;
    logic [2:0] id_rs1_i;
    logic [2:0] id_rs2_i;
    logic       id_rs1_used_i;
    logic       id_rs2_used_i;
    logic       id_reg_write_i;
    logic [2:0] id_rd_i;
    logic       halt_req_i;
    logic       resume_i;
    logic       step_i;

    logic        pc_hold_o, bubble_o, halted_o;
    logic [15:0] stall_cnt_o, issue_cnt_o;
    logic        s_pc_hold, s_bubble, s_halted;
    logic [3:0]  s_stall_cnt, s_issue_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic        hold;
        logic        halted;
        logic [15:0] stall;
        logic [15:0] issue;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk_i = ~clk_i;

    hazard_run_ctrl #(.REG_AW(3), .CNT_W(16), .SB_DEPTH(3)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_reg_write_i(id_reg_write_i), .id_rd_i(id_rd_i),
        .halt_req_i(halt_req_i), .resume_i(resume_i), .step_i(step_i),
        .pc_hold_o(pc_hold_o), .bubble_o(bubble_o), .halted_o(halted_o),
        .stall_cnt_o(stall_cnt_o), .issue_cnt_o(issue_cnt_o)
    );

    hazard_run_ctrl #(.REG_AW(3), .CNT_W(4), .SB_DEPTH(3)) dut_sat (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_reg_write_i(id_reg_write_i), .id_rd_i(id_rd_i),
        .halt_req_i(halt_req_i), .resume_i(resume_i), .step_i(step_i),
        .pc_hold_o(s_pc_hold), .bubble_o(s_bubble), .halted_o(s_halted),
        .stall_cnt_o(s_stall_cnt), .issue_cnt_o(s_issue_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_underflow observed=0 expected=1");
            return;
        end
        e = sb_q.pop_front();
        case (e.kind)
            0: begin
                chk({e.tag, "/pc_hold"},   {15'd0, pc_hold_o}, {15'd0, e.hold});
                chk({e.tag, "/bubble"},    {15'd0, bubble_o},  {15'd0, e.hold});
                chk({e.tag, "/halted"},    {15'd0, halted_o},  {15'd0, e.halted});
                chk({e.tag, "/sat_hold"},  {15'd0, s_pc_hold}, {15'd0, e.hold});
                chk({e.tag, "/sat_bub"},   {15'd0, s_bubble},  {15'd0, e.hold});
                chk({e.tag, "/sat_halt"},  {15'd0, s_halted},  {15'd0, e.halted});
            end
            1: begin
                chk({e.tag, "/stall_cnt"}, stall_cnt_o, e.stall);
                chk({e.tag, "/issue_cnt"}, issue_cnt_o, e.issue);
            end
            default: begin
                chk({e.tag, "/sat_stall"}, {12'd0, s_stall_cnt}, e.stall);
                chk({e.tag, "/sat_issue"}, {12'd0, s_issue_cnt}, e.issue);
            end
        endcase
    endtask

    task automatic push(input string tag, input int kind, input logic hold, input logic halted,
                        input logic [15:0] stall, input logic [15:0] issue);
        exp_t e;
        e.tag = tag; e.kind = kind; e.hold = hold; e.halted = halted;
        e.stall = stall; e.issue = issue;
        sb_q.push_back(e);
    endtask

    // One clock cycle: expectation queued with the stimulus, checked at negedge.
    task automatic cyc(input string tag, input logic hold, input logic halted);
        push(tag, 0, hold, halted, 16'd0, 16'd0);
        @(negedge clk_i);
        compare_front();
        @(posedge clk_i);
        #1;
    endtask

    task automatic now_chk(input string tag, input logic hold, input logic halted);
        push(tag, 0, hold, halted, 16'd0, 16'd0);
        compare_front();
    endtask

    task automatic cnt(input string tag, input logic [15:0] stall, input logic [15:0] issue);
        push(tag, 1, 1'b0, 1'b0, stall, issue);
        compare_front();
    endtask

    task automatic sat(input string tag, input logic [15:0] stall, input logic [15:0] issue);
        push(tag, 2, 1'b0, 1'b0, stall, issue);
        compare_front();
    endtask

    task automatic drive(input logic v, input logic [2:0] rs1, input logic u1,
                         input logic [2:0] rs2, input logic u2, input logic wr, input logic [2:0] rd);
        id_valid_i = v; id_rs1_i = rs1; id_rs1_used_i = u1;
        id_rs2_i = rs2; id_rs2_used_i = u2; id_reg_write_i = wr; id_rd_i = rd;
    endtask

    task automatic ctl(input logic h, input logic r, input logic s);
        halt_req_i = h; resume_i = r; step_i = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        ctl(0, 0, 0);
        cyc("in_reset", 0, 0);
        cnt("in_reset", 0, 0);
        rst_n_i = 1'b1;

        // back-to-back RAW: 3 stall cycles, issue on the 4th
        drive(1, 1, 1, 2, 1, 1, 3); cyc("raw_prod", 0, 0);
        drive(1, 3, 1, 1, 1, 1, 4);
        cyc("raw_stall1", 1, 0); cyc("raw_stall2", 1, 0); cyc("raw_stall3", 1, 0);
        cyc("raw_issue", 0, 0);
        cnt("raw_cnt", 3, 2);

        // two independent in between: 1 stall
        drive(1, 1, 1, 2, 1, 1, 5); cyc("ind1", 0, 0);
        drive(1, 1, 1, 2, 1, 1, 6); cyc("ind2", 0, 0);
        drive(1, 4, 1, 0, 0, 1, 7); cyc("dist2_stall", 1, 0); cyc("dist2_issue", 0, 0);
        cnt("dist2_cnt", 4, 5);

        // r0 producer/consumer and unused source fields
        drive(1, 1, 1, 2, 1, 1, 0); cyc("r0_prod", 0, 0);
        drive(1, 0, 1, 0, 1, 1, 1); cyc("r0_cons", 0, 0);
        drive(1, 1, 0, 7, 0, 0, 0); cyc("unused_src", 0, 0);
        cnt("r0_cnt", 4, 8);

        // halt with 3 in flight; step during DRAIN is ignored
        drive(1, 0, 0, 0, 0, 1, 5); cyc("pre_halt1", 0, 0);
        drive(1, 0, 0, 0, 0, 1, 6); cyc("pre_halt2", 0, 0);
        drive(1, 0, 0, 0, 0, 1, 7); ctl(1, 0, 0); cyc("halt_req", 0, 0);
        ctl(0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 2);
        cyc("drain1", 1, 0);
        ctl(0, 0, 1); cyc("drain2_step", 1, 0); ctl(0, 0, 0);
        cyc("drain3", 1, 0);
        cyc("halted", 1, 1);
        cnt("halt_cnt", 4, 11);
        cyc("halted_hold", 1, 1);

        // single step of the frozen instruction, then drain back to HALTED
        ctl(0, 0, 1); cyc("step_pulse", 1, 1); ctl(0, 0, 0);
        cyc("step_issue", 0, 0);
        cnt("step_cnt", 4, 12);
        drive(1, 2, 1, 0, 0, 1, 4);
        cyc("step_drain1", 1, 0); cyc("step_drain2", 1, 0); cyc("step_drain3", 1, 0);
        cyc("step_halted", 1, 1);
        cnt("step_nostall", 4, 12);

        // step onto the formerly hazarding instruction
        ctl(0, 0, 1); cyc("step2_pulse", 1, 1); ctl(0, 0, 0);
        cyc("step2_issue", 0, 0);
        cnt("step2_cnt", 4, 13);
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc("step2_drain1", 1, 0); cyc("step2_drain2", 1, 0); cyc("step2_drain3", 1, 0);
        cyc("step2_halted", 1, 1);

        // step with an empty ID waits for a valid instruction
        ctl(0, 0, 1); cyc("step3_pulse", 1, 1); ctl(0, 0, 0);
        cyc("step3_wait1", 1, 0); cyc("step3_wait2", 1, 0);
        drive(1, 0, 0, 0, 0, 1, 3); cyc("step3_issue", 0, 0);
        cnt("step3_cnt", 4, 14);
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc("step3_drain1", 1, 0); cyc("step3_drain2", 1, 0); cyc("step3_drain3", 1, 0);
        cyc("step3_halted", 1, 1);

        // resume and step together: resume wins, no re-halt
        drive(1, 0, 0, 0, 0, 0, 0);
        ctl(0, 1, 1); cyc("res_step_pulse", 1, 1); ctl(0, 0, 0);
        cyc("resume_issue", 0, 0);
        cyc("resume_run", 0, 0);
        cnt("resume_cnt", 4, 16);

        // async reset in the second hazard cycle
        drive(1, 0, 0, 0, 0, 1, 5); cyc("rst_prod", 0, 0);
        drive(1, 5, 1, 0, 0, 1, 6); cyc("rst_stall1", 1, 0);
        cnt("rst_pre", 5, 17);
        rst_n_i = 1'b0;
        #1;
        now_chk("rst_async", 0, 0);
        cnt("rst_async", 0, 0);
        sat("rst_async", 0, 0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        cyc("rst_first_issue", 0, 0);
        cnt("rst_after", 0, 1);

        // chained r1 <- r1: 7 dependent issues x 3 stalls = 21 stalls
        drive(1, 1, 1, 0, 0, 1, 1);
        cyc("chain_first", 0, 0);
        for (int i = 0; i < 7; i++) begin
            cyc("chain_stall1", 1, 0);
            cyc("chain_stall2", 1, 0);
            cyc("chain_stall3", 1, 0);
            cyc("chain_issue", 0, 0);
        end
        cnt("chain_main", 21, 9);
        sat("chain_sat", 15, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
